pdm_cic_decimator: RTL and testbench

- Front-end of the record path, between the PDM microphone pins and the record memory write logic.
- Generates the microphone bit clock and captures the 1-bit PDM stream.
- Converts the stream to signed 16-bit PCM with a 3rd-order CIC decimator.
- Presents each PCM word with a one-cycle valid pulse; consumers advance the memory address on that pulse.

---
 rtl/audio_pkg.sv | 28 ++
 rtl/pdm_clock_gen.sv | 42 ++++
 rtl/pdm_cic_decimator.sv | 190 +++++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path constants and types for the PDM record front-end and the
// playback serializer.
package audio_pkg;

  localparam int DEFAULT_WORD_LENGTH      = 16;
  localparam int DEFAULT_SYSTEM_FREQUENCY = 100_000_000;
  localparam int DEFAULT_PDM_FREQUENCY    = 2_000_000;
  localparam int DEFAULT_DECIMATION       = 64;
  localparam int DEFAULT_ORDER            = 3;

  // Worst-case CIC register growth plus a sign bit and one bit of headroom.
  function automatic int cic_acc_width(input int order, input int decimation);
    return order * $clog2(decimation) + 2;
  endfunction

  localparam int ACC_W = cic_acc_width(DEFAULT_ORDER, DEFAULT_DECIMATION);
  localparam int HALF  = DEFAULT_SYSTEM_FREQUENCY / DEFAULT_PDM_FREQUENCY / 2;
  localparam int SHIFT = ACC_W - 1 - DEFAULT_WORD_LENGTH;

  typedef logic signed [DEFAULT_WORD_LENGTH-1:0] pcm_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } dec_state_t;

endpackage

// File: rtl/pdm_clock_gen.sv
// Half-period divider producing the microphone bit clock and a strobe on the
// cycle in which that clock is driven high-to-low.
module pdm_clock_gen
  import audio_pkg::*;
#(
  parameter int HALF_CYCLES = HALF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_pdm_clk,
  output logic o_bit_strobe
);

  localparam int DIV_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_clk;
  logic             w_wrap;

  assign w_wrap       = (r_div == DIV_W'(HALF_CYCLES - 1));
  assign o_pdm_clk    = r_clk;
  assign o_bit_strobe = i_run && w_wrap && r_clk;

  // Dropping i_run parks the clock low with the divider at zero, so the next
  // run starts with a full low half-period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
      r_clk <= 1'b0;
    end else if (!i_run) begin
      r_div <= '0;
      r_clk <= 1'b0;
    end else if (w_wrap) begin
      r_div <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front-end: bit clock generation, input capture and an
// ORDER-stage CIC decimator producing saturated signed PCM words.
module pdm_cic_decimator
  import audio_pkg::*;
#(
  parameter int WORD_LENGTH      = DEFAULT_WORD_LENGTH,
  parameter int SYSTEM_FREQUENCY = DEFAULT_SYSTEM_FREQUENCY,
  parameter int PDM_FREQUENCY    = DEFAULT_PDM_FREQUENCY,
  parameter int DECIMATION       = DEFAULT_DECIMATION,
  parameter int ORDER            = DEFAULT_ORDER
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  output logic                   pdm_clk_o,
  input  logic                   pdm_data_i,
  output logic                   pdm_lrsel_o,
  output logic [WORD_LENGTH-1:0] sample_o,
  output logic                   sample_valid_o,
  output logic                   busy_o
);

  localparam int HALF_PERIOD = SYSTEM_FREQUENCY / PDM_FREQUENCY / 2;
  localparam int ACC_WIDTH   = cic_acc_width(ORDER, DECIMATION);
  localparam int OUT_SHIFT   = ACC_WIDTH - 1 - WORD_LENGTH;
  localparam int CNT_W       = $clog2(DECIMATION);
  localparam int WARM_W      = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic signed [ACC_WIDTH-1:0] PCM_MAX = ACC_WIDTH'((1 << (WORD_LENGTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] PCM_MIN = ~PCM_MAX;

  function automatic logic [WORD_LENGTH-1:0] scale_sat(input logic signed [ACC_WIDTH-1:0] x);
    logic signed [ACC_WIDTH-1:0] s;
    s = x >>> OUT_SHIFT;
    if (s > PCM_MAX) return PCM_MAX[WORD_LENGTH-1:0];
    if (s < PCM_MIN) return PCM_MIN[WORD_LENGTH-1:0];
    return s[WORD_LENGTH-1:0];
  endfunction

  dec_state_t                  r_state;
  logic [WARM_W-1:0]           r_warm;
  logic                        r_busy;
  logic                        r_valid;
  logic [WORD_LENGTH-1:0]      r_sample;
  logic [1:0]                  r_sync;
  logic [CNT_W-1:0]            r_bit_cnt;
  logic signed [ACC_WIDTH-1:0] r_dec;
  logic [ORDER:0]              r_vld;

  logic                        w_run;
  logic                        w_strobe;
  logic                        w_pdm_clk;
  logic                        w_dec_strobe;
  logic signed [ACC_WIDTH-1:0] w_bit;
  logic signed [ACC_WIDTH-1:0] w_int_out;
  logic signed [ACC_WIDTH-1:0] w_comb_out;

  assign w_run        = (r_state != IDLE) && enable_i;
  assign w_dec_strobe = w_strobe && (r_bit_cnt == CNT_W'(DECIMATION - 1));
  assign w_bit        = r_sync[1] ? ACC_WIDTH'(1) : ACC_WIDTH'(-1);

  assign pdm_clk_o      = w_pdm_clk;
  assign pdm_lrsel_o    = 1'b0;
  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign busy_o         = r_busy;

  pdm_clock_gen #(
    .HALF_CYCLES(HALF_PERIOD)
  ) u_clock_gen (
    .i_clk       (clock_i),
    .i_rst       (reset_i),
    .i_run       (w_run),
    .o_pdm_clk   (w_pdm_clk),
    .o_bit_strobe(w_strobe)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_sync <= '0;
    else         r_sync <= {r_sync[0], pdm_data_i};
  end

  // Integrator cascade at the PDM bit rate; modular wrap is relied upon.
  for (genvar g = 0; g < ORDER; g++) begin : g_int
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_in;
    logic signed [ACC_WIDTH-1:0] w_nxt;

    if (g == 0) begin : g_first
      assign w_in = w_bit;
    end else begin : g_chain
      assign w_in = g_int[g-1].w_nxt;
    end
    assign w_nxt = r_acc + w_in;

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)       r_acc <= '0;
      else if (!w_run)   r_acc <= '0;
      else if (w_strobe) r_acc <= w_nxt;
    end
  end

  assign w_int_out = g_int[ORDER-1].w_nxt;

  // Decimation point: r_vld[0] marks a fresh value in r_dec.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i || !w_run) begin
      r_bit_cnt <= '0;
      r_dec     <= '0;
      r_vld     <= '0;
    end else begin
      if (w_strobe)     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_dec_strobe) r_dec     <= w_int_out;
      r_vld <= {r_vld[ORDER-1:0], w_dec_strobe};
    end
  end

  // Comb cascade, one stage per clock cycle, differential delay of one output.
  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    logic signed [ACC_WIDTH-1:0] r_dly;
    logic signed [ACC_WIDTH-1:0] r_out;
    logic signed [ACC_WIDTH-1:0] w_in;

    if (g == 0) begin : g_first
      assign w_in = r_dec;
    end else begin : g_chain
      assign w_in = g_comb[g-1].r_out;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i || !w_run) begin
        r_dly <= '0;
        r_out <= '0;
      end else if (r_vld[g]) begin
        r_out <= w_in - r_dly;
        r_dly <= w_in;
      end
    end
  end

  assign w_comb_out = g_comb[ORDER-1].r_out;

  // Control FSM; sample_o deliberately survives a drop back to IDLE.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_warm   <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_sample <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_warm <= '0;
          if (enable_i) begin
            r_state <= WARMUP;
            r_busy  <= 1'b1;
          end
        end
        WARMUP: begin
          if (!enable_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_vld[ORDER]) begin
            if (r_warm == WARM_W'(ORDER - 1)) begin
              r_state <= RUN;
              r_warm  <= '0;
            end else begin
              r_warm <= r_warm + WARM_W'(1);
            end
          end
        end
        RUN: begin
          if (!enable_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_vld[ORDER]) begin
            r_sample <= scale_sat(w_comb_out);
            r_valid  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench for pdm_cic_decimator: directed PDM patterns with
// hand-computed PCM results and cycle-exact valid timing.
module tb_pdm_cic_decimator;
  import audio_pkg::*;

  typedef struct {
    pcm_t val;
    bit   chk;
  } exp_t;

  logic                           clock_i = 1'b0;
  logic                           reset_i;
  logic                           enable_i;
  logic                           pdm_clk_o;
  logic                           pdm_data_i;
  logic                           pdm_lrsel_o;
  logic [DEFAULT_WORD_LENGTH-1:0] sample_o;
  logic                           sample_valid_o;
  logic                           busy_o;

  exp_t exp_q[$];
  int   vcyc_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   mode = 1;
  int   bit_idx = 0;
  bit   pdm_prev = 1'b0;
  bit   prev_vld = 1'b0;

  pdm_cic_decimator dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .pdm_clk_o     (pdm_clk_o),
    .pdm_data_i    (pdm_data_i),
    .pdm_lrsel_o   (pdm_lrsel_o),
    .sample_o      (sample_o),
    .sample_valid_o(sample_valid_o),
    .busy_o        (busy_o)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic pattern(input int m, input int idx);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (idx % 2) == 0;
      default: return (idx % 4) != 3;
    endcase
  endfunction

  task automatic push(input int v, input bit c, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{val: pcm_t'(v), chk: c});
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clock_i);
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      @(negedge clock_i);
      b--;
    end
    if (b == 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Microphone model: a new bit is presented just after each rising edge.
  initial begin
    pdm_data_i = 1'b0;
    forever begin
      @(negedge clock_i);
      if (pdm_clk_o && !pdm_prev) begin
        bit_idx++;
        pdm_data_i = pattern(mode, bit_idx);
      end
      pdm_prev = pdm_clk_o;
    end
  end

  // Monitor: pops one expectation per valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_i);
      if (!reset_i && sample_valid_o) begin
        vcyc_q.push_back(cyc);
        check("valid_back_to_back", int'(prev_vld), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", $signed(sample_o), 99999);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check("sample", $signed(sample_o), int'(e.val));
        end
      end
      prev_vld = sample_valid_o;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int v;
    reset_i  = 1'b1;
    enable_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check("rst_sample", $signed(sample_o), 0);
    check("rst_valid", int'(sample_valid_o), 0);
    check("rst_pdm_clk", int'(pdm_clk_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_lrsel", int'(pdm_lrsel_o), 0);
    reset_i = 1'b0;
    repeat (5) @(negedge clock_i);
    check("idle_pdm_clk", int'(pdm_clk_o), 0);
    check("idle_busy", int'(busy_o), 0);

    // All ones: saturates at +32767; clock shape and first-valid latency.
    mode = 1;
    push(32767, 1'b1, 3);
    vcyc_q.delete();
    k = cyc;
    enable_i = 1'b1;
    wait_to(k + 1);
    check("busy_warmup", int'(busy_o), 1);
    wait_to(k + 25);
    check("clk_before_rise", int'(pdm_clk_o), 0);
    wait_to(k + 26);
    check("clk_first_rise", int'(pdm_clk_o), 1);
    wait_to(k + 50);
    check("clk_high_end", int'(pdm_clk_o), 1);
    wait_to(k + 51);
    check("clk_fall", int'(pdm_clk_o), 0);
    wait_to(k + 75);
    check("clk_low_end", int'(pdm_clk_o), 0);
    wait_to(k + 76);
    check("clk_second_rise", int'(pdm_clk_o), 1);
    drain(20000);
    check("ones_valid_count", vcyc_q.size(), 3);
    if (vcyc_q.size() == 3) begin
      check("first_valid_cycle", vcyc_q[0] - k, 12805);
      check("valid_spacing_1", vcyc_q[1] - vcyc_q[0], 3200);
      check("valid_spacing_2", vcyc_q[2] - vcyc_q[1], 3200);
    end

    // Enable drops on the cycle a valid is due: no pulse, sample retained.
    v = (vcyc_q.size() > 0) ? vcyc_q[vcyc_q.size()-1] : cyc;
    wait_to(v + 3199);
    enable_i = 1'b0;
    wait_to(v + 3200);
    check("drop_valid", int'(sample_valid_o), 0);
    check("drop_sample_kept", $signed(sample_o), 32767);
    check("drop_busy", int'(busy_o), 0);
    check("drop_pdm_clk", int'(pdm_clk_o), 0);
    repeat (100) @(negedge clock_i);

    // All zeros: -32768, then asynchronous reset mid-run between strobes.
    mode = 0;
    push(-32768, 1'b1, 1);
    vcyc_q.delete();
    k = cyc;
    enable_i = 1'b1;
    drain(20000);
    check("zeros_valid_count", vcyc_q.size(), 1);
    v = cyc;
    if (vcyc_q.size() == 1) begin
      check("zeros_first_valid", vcyc_q[0] - k, 12805);
      v = vcyc_q[0];
    end
    wait_to(v + 100);
    reset_i = 1'b1;
    #1;
    check("midrun_rst_sample", $signed(sample_o), 0);
    check("midrun_rst_valid", int'(sample_valid_o), 0);
    check("midrun_rst_pdm_clk", int'(pdm_clk_o), 0);
    check("midrun_rst_busy", int'(busy_o), 0);
    repeat (2) @(negedge clock_i);
    enable_i = 1'b0;
    reset_i  = 1'b0;
    repeat (5) @(negedge clock_i);

    // Alternating 1,0 gives 0 after a full warmup; then 75% ones gives 16384.
    mode = 2;
    push(0, 1'b1, 1);
    vcyc_q.delete();
    k = cyc;
    enable_i = 1'b1;
    wait_to(k + 25);
    check("rerun_clk_before_rise", int'(pdm_clk_o), 0);
    wait_to(k + 26);
    check("rerun_clk_first_rise", int'(pdm_clk_o), 1);
    drain(20000);
    check("alt_valid_count", vcyc_q.size(), 1);
    if (vcyc_q.size() == 1) check("rerun_first_valid", vcyc_q[0] - k, 12805);
    mode = 3;
    push(16384, 1'b0, 3);
    push(16384, 1'b1, 3);
    drain(25000);
    check("pct75_valid_count", vcyc_q.size(), 7);
    if (vcyc_q.size() == 7) check("pct75_spacing", vcyc_q[6] - vcyc_q[5], 3200);
    enable_i = 1'b0;
    repeat (10) @(negedge clock_i);
    check("end_busy", int'(busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
